// File: rtl/frame_plotter_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_plotter_if
// Brief    : Scene-input / pixel-output bundle between the game datapath,
//            the frame plotter and the VGA frame-buffer adapter.
// Revision : 1.0 - initial release
// ============================================================================
interface frame_plotter_if;
    logic       start;
    logic [7:0] dude_x;
    logic [6:0] dude_y;
    logic [7:0] obs_x;
    logic [6:0] obs_gap_y;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport slave (
        input  start, dude_x, dude_y, obs_x, obs_gap_y,
        output x, y, colour, plot, busy, done
    );

    modport master (
        output start, dude_x, dude_y, obs_x, obs_gap_y,
        input  x, y, colour, plot, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/frame_plotter.sv
`default_nettype none
// ============================================================================
// Module   : frame_plotter
// Brief    : Sweeps the full screen once per start pulse, one pixel per clock,
//            colouring each pixel from a latched snapshot of the scene.
// Revision : 1.0 - initial release
// ============================================================================
module frame_plotter #(
    parameter int         WIDTH      = 160,
    parameter int         HEIGHT     = 120,
    parameter int         DUDE_SIZE  = 4,
    parameter int         OBS_WIDTH  = 8,
    parameter int         GAP_HEIGHT = 32,
    parameter int         WALL_ROWS  = 4,
    parameter logic [2:0] C_BG       = 3'b000,
    parameter logic [2:0] C_WALL     = 3'b111,
    parameter logic [2:0] C_OBS      = 3'b010,
    parameter logic [2:0] C_DUDE     = 3'b100
) (
    input  wire logic       clk,
    input  wire logic       resetn,
    frame_plotter_if.slave  bus
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_scan   = 2'd1;
    localparam logic [1:0] c_finish = 2'd2;

    localparam logic [7:0] c_x_last      = 8'(WIDTH - 1);
    localparam logic [6:0] c_y_last      = 7'(HEIGHT - 1);
    localparam logic [6:0] c_wall_top    = 7'(WALL_ROWS);
    localparam logic [6:0] c_wall_bot    = 7'(HEIGHT - WALL_ROWS);
    localparam logic [8:0] c_dude_span_x = 9'(DUDE_SIZE - 1);
    localparam logic [7:0] c_dude_span_y = 8'(DUDE_SIZE - 1);
    localparam logic [8:0] c_obs_span    = 9'(OBS_WIDTH - 1);
    localparam logic [7:0] c_gap_span    = 8'(GAP_HEIGHT - 1);

    logic [1:0] r_state;
    logic [7:0] r_cx;
    logic [6:0] r_cy;
    logic [7:0] r_dx;
    logic [6:0] r_dy;
    logic [7:0] r_ox;
    logic [6:0] r_gy;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_colour;
    logic       r_plot;
    logic       r_busy;
    logic       r_done;

    // One extra bit on every compare so a sprite's far edge clips at the
    // screen border instead of wrapping round to column/row 0.
    logic [8:0] w_px;
    logic [7:0] w_py;
    logic [8:0] w_dx;
    logic [7:0] w_dy;
    logic [8:0] w_ox;
    logic [7:0] w_gy;
    logic       w_in_dude;
    logic       w_in_gap;
    logic       w_in_obs;
    logic       w_in_wall;
    logic [2:0] w_colour;

    assign w_px = {1'b0, r_cx};
    assign w_py = {1'b0, r_cy};
    assign w_dx = {1'b0, r_dx};
    assign w_dy = {1'b0, r_dy};
    assign w_ox = {1'b0, r_ox};
    assign w_gy = {1'b0, r_gy};

    assign w_in_dude = (w_px >= w_dx) && (w_px <= w_dx + c_dude_span_x) &&
                       (w_py >= w_dy) && (w_py <= w_dy + c_dude_span_y);
    assign w_in_gap  = (w_py >= w_gy) && (w_py <= w_gy + c_gap_span);
    assign w_in_obs  = (w_px >= w_ox) && (w_px <= w_ox + c_obs_span) && !w_in_gap;
    assign w_in_wall = (r_cy < c_wall_top) || (r_cy >= c_wall_bot);

    always_comb begin
        w_colour = C_BG;
        if (w_in_dude) begin
            w_colour = C_DUDE;
        end else if (w_in_obs) begin
            w_colour = C_OBS;
        end else if (w_in_wall) begin
            w_colour = C_WALL;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= c_idle;
            r_cx     <= 8'd0;
            r_cy     <= 7'd0;
            r_dx     <= 8'd0;
            r_dy     <= 7'd0;
            r_ox     <= 8'd0;
            r_gy     <= 7'd0;
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_colour <= C_BG;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_plot <= 1'b0;
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_dx    <= bus.dude_x;
                        r_dy    <= bus.dude_y;
                        r_ox    <= bus.obs_x;
                        r_gy    <= bus.obs_gap_y;
                        r_cx    <= 8'd0;
                        r_cy    <= 7'd0;
                        r_busy  <= 1'b1;
                        r_state <= c_scan;
                    end
                end
                c_scan: begin
                    r_x      <= r_cx;
                    r_y      <= r_cy;
                    r_colour <= w_colour;
                    r_plot   <= 1'b1;
                    if (r_cx == c_x_last) begin
                        r_cx <= 8'd0;
                        if (r_cy == c_y_last) begin
                            r_state <= c_finish;
                        end else begin
                            r_cy <= r_cy + 7'd1;
                        end
                    end else begin
                        r_cx <= r_cx + 8'd1;
                    end
                end
                c_finish: begin
                    // Stay here through the done cycle so a start raised
                    // alongside done is not taken.
                    r_plot <= 1'b0;
                    if (!r_done) begin
                        r_done <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign bus.x      = r_x;
    assign bus.y      = r_y;
    assign bus.colour = r_colour;
    assign bus.plot   = r_plot;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_frame_plotter.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_plotter
// Brief    : Directed frame captures with pixel-colour vector tables.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frame_plotter;

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] col;
    } pix_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    frame_plotter_if bus ();

    frame_plotter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int first_plot, plot_cnt, done_at, done_cnt, busy_drop, order_err;
    logic [2:0] fb [0:19199];

    pix_t t1 [15];
    pix_t ta [13];
    pix_t tb [11];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_pix(input pix_t p);
        chk($sformatf("pixel(%0d,%0d)", p.px, p.py),
            int'(fb[int'(p.py) * 160 + int'(p.px)]), int'(p.col));
    endtask

    task automatic set_scene(input int dx, input int dy, input int ox, input int gy);
        bus.dude_x    = 8'(dx);
        bus.dude_y    = 7'(dy);
        bus.obs_x     = 8'(ox);
        bus.obs_gap_y = 7'(gy);
    endtask

    // Called at the negedge just after the edge that accepted start;
    // k counts edges since that acceptance edge.
    task automatic capture(input int ncyc, input int poke_k);
        int ex = 0;
        int ey = 0;
        for (int i = 0; i < 19200; i++) fb[i] = 3'b101;
        first_plot = -1; plot_cnt = 0; done_at = -1; done_cnt = 0;
        busy_drop = -1; order_err = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (bus.plot) begin
                if (first_plot < 0) first_plot = k;
                if (int'(bus.x) != ex || int'(bus.y) != ey) order_err++;
                if (bus.x < 8'd160 && bus.y < 7'd120)
                    fb[int'(bus.y) * 160 + int'(bus.x)] = bus.colour;
                plot_cnt++;
                if (ex == 159) begin ex = 0; ey++; end else ex++;
            end else if (plot_cnt > 0 && plot_cnt < 19200) begin
                order_err++;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (!bus.busy && busy_drop < 0) busy_drop = k;
            if (k == poke_k) begin bus.start = 1'b1; bus.dude_x = 8'd80; end
            if (k == poke_k + 1) bus.start = 1'b0;
        end
    endtask

    task automatic chk_frame(input string tag);
        chk({tag, " first_plot_cycle"}, first_plot, 1);
        chk({tag, " plot_count"},       plot_cnt, 19200);
        chk({tag, " done_cycle"},       done_at, 19201);
        chk({tag, " done_pulses"},      done_cnt, 1);
        chk({tag, " busy_fall_cycle"},  busy_drop, 19202);
        chk({tag, " raster_order_errs"}, order_err, 0);
    endtask

    initial begin
        int bad;
        // scene (10,50) obs 100 gap 40
        t1 = '{'{8'd10, 7'd50, 3'b100}, '{8'd13, 7'd53, 3'b100}, '{8'd14, 7'd50, 3'b000},
               '{8'd13, 7'd54, 3'b000}, '{8'd9, 7'd52, 3'b000},  '{8'd100, 7'd20, 3'b010},
               '{8'd100, 7'd40, 3'b000}, '{8'd100, 7'd71, 3'b000}, '{8'd100, 7'd72, 3'b010},
               '{8'd107, 7'd20, 3'b010}, '{8'd108, 7'd20, 3'b000}, '{8'd103, 7'd0, 3'b010},
               '{8'd50, 7'd2, 3'b111},  '{8'd50, 7'd116, 3'b111}, '{8'd50, 7'd115, 3'b000}};
        // scene (158,118) obs 155 gap 40
        ta = '{'{8'd158, 7'd118, 3'b100}, '{8'd159, 7'd119, 3'b100}, '{8'd158, 7'd119, 3'b100},
               '{8'd159, 7'd118, 3'b100}, '{8'd157, 7'd118, 3'b010}, '{8'd158, 7'd117, 3'b010},
               '{8'd0, 7'd0, 3'b111},     '{8'd1, 7'd119, 3'b111},   '{8'd155, 7'd0, 3'b010},
               '{8'd159, 7'd40, 3'b000},  '{8'd159, 7'd71, 3'b000},  '{8'd154, 7'd20, 3'b000},
               '{8'd155, 7'd72, 3'b010}};
        // scene dude (200,50) off-screen, obs 20, gap 100 running past the bottom
        tb = '{'{8'd20, 7'd110, 3'b000}, '{8'd27, 7'd100, 3'b000}, '{8'd20, 7'd99, 3'b010},
               '{8'd27, 7'd50, 3'b010},  '{8'd28, 7'd50, 3'b000},  '{8'd19, 7'd50, 3'b000},
               '{8'd20, 7'd119, 3'b111}, '{8'd20, 7'd0, 3'b010},   '{8'd10, 7'd50, 3'b000},
               '{8'd0, 7'd2, 3'b111},    '{8'd159, 7'd117, 3'b111}};

        resetn = 1'b0;
        bus.start = 1'b0;
        set_scene(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset x", int'(bus.x), 0);
        chk("reset y", int'(bus.y), 0);
        chk("reset colour", int'(bus.colour), 0);
        chk("reset plot", int'(bus.plot), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        resetn = 1'b1;
        @(negedge clk);

        // Frame 1 with an ignored start pulse and dude_x change mid-frame
        set_scene(10, 50, 100, 40);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("f1 busy_after_accept", int'(bus.busy), 1);
        chk("f1 plot_after_accept", int'(bus.plot), 0);
        capture(19205, 5000);
        chk_frame("f1");
        for (int i = 0; i < 15; i++) chk_pix(t1[i]);

        // Back-to-back frames with start held high
        set_scene(158, 118, 155, 40);
        bus.start = 1'b1;
        @(negedge clk);
        set_scene(200, 50, 20, 100);
        capture(19202, -10);
        chk_frame("fa");
        for (int i = 0; i < 13; i++) chk_pix(ta[i]);
        @(negedge clk);
        chk("fb busy_after_idle_cycle", int'(bus.busy), 1);
        bus.start = 1'b0;
        capture(19203, -10);
        chk_frame("fb");
        for (int i = 0; i < 11; i++) chk_pix(tb[i]);

        // Reset in the middle of a frame
        set_scene(10, 50, 100, 40);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4841) @(negedge clk);
        chk("mid x_before_reset", int'(bus.x), 40);
        chk("mid y_before_reset", int'(bus.y), 30);
        chk("mid plot_before_reset", int'(bus.plot), 1);
        resetn = 1'b0;
        @(negedge clk);
        chk("mid plot_after_reset", int'(bus.plot), 0);
        chk("mid busy_after_reset", int'(bus.busy), 0);
        chk("mid done_after_reset", int'(bus.done), 0);
        chk("mid x_after_reset", int'(bus.x), 0);
        resetn = 1'b1;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.plot || bus.done || bus.busy) bad++;
        end
        chk("mid activity_after_release", bad, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("restart busy", int'(bus.busy), 1);
        @(negedge clk);
        chk("restart plot", int'(bus.plot), 1);
        chk("restart x", int'(bus.x), 0);
        chk("restart y", int'(bus.y), 0);
        chk("restart colour", int'(bus.colour), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
